fpga_cfg_loader: RTL and testbench

//  Writer end of the fabric configuration chain. Takes config bytes from the tile pins
//  (ui_in/uio_in via tt_um_top) over a valid/ready handshake. Serialises them LSB-first

---
 rtl/cfg_pkg.sv | 26 ++
 rtl/cfg_byte_serializer.sv | 41 ++++
 rtl/fpga_cfg_loader.sv | 107 ++++++++++
 tb/tb_fpga_cfg_loader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared types and helpers for the fabric configuration loader: FSM states,
// byte width, default chain length and the running checksum step.
package cfg_pkg;

    localparam int CFG_BYTE_W        = 8;
    localparam int CFG_CHAIN_LEN_DEF = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_CHECK,
        ST_LATCH,
        ST_DONE,
        ST_ERR
    } cfg_state_t;

    // One step of the 8-bit XOR fold over the image bytes.
    function automatic logic [CFG_BYTE_W-1:0] cfg_csum_fold(
        input logic [CFG_BYTE_W-1:0] acc,
        input logic [CFG_BYTE_W-1:0] b
    );
        return acc ^ b;
    endfunction

endpackage

// File: rtl/cfg_byte_serializer.sv
// 8-bit parallel-in serial-out shifter, LSB first. A load starts an 8-cycle
// burst; sdo is forced low whenever the shifter is idle.
module cfg_byte_serializer
    import cfg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [CFG_BYTE_W-1:0] byte_i,
    output logic                  sdo_o,
    output logic                  busy_o,
    output logic                  last_o
);

    logic [CFG_BYTE_W-1:0] sreg_q;
    logic [2:0]            bit_q;
    logic                  busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            bit_q  <= '0;
            busy_q <= 1'b0;
        end else if (load_i) begin
            sreg_q <= byte_i;
            bit_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            sreg_q <= {1'b0, sreg_q[CFG_BYTE_W-1:1]};
            bit_q  <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign sdo_o  = busy_q & sreg_q[0];
    assign busy_o = busy_q;
    assign last_o = busy_q && (bit_q == 3'd7);

endmodule

// File: rtl/fpga_cfg_loader.sv
// Writer end of the fabric configuration chain: accepts bytes over valid/ready,
// shifts them into the chain and pulses chain_latch only on a good checksum.
module fpga_cfg_loader
    import cfg_pkg::*;
#(
    parameter int CHAIN_LEN = CFG_CHAIN_LEN_DEF,
    parameter int CNT_W     = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic [CFG_BYTE_W-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  chain_sdo,
    output logic                  chain_shift_en,
    output logic                  chain_latch,
    output logic                  done,
    output logic                  err
);

    localparam logic [CNT_W-1:0] N_BYTES = CNT_W'(CHAIN_LEN / CFG_BYTE_W);

    cfg_state_t            state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CFG_BYTE_W-1:0] csum_q, csum_d;
    logic                  ready_q, shift_q, latch_q, done_q, err_q;
    logic                  accept, ser_load, ser_sdo, ser_busy, ser_last;

    // A start request always wins over a coincident byte.
    assign cfg_ready = ready_q & ~cfg_start;
    assign accept    = cfg_ready & cfg_valid;
    assign ser_load  = accept && (state_q == ST_LOAD);

    cfg_byte_serializer u_ser (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (ser_load),
        .byte_i (cfg_data),
        .sdo_o  (ser_sdo),
        .busy_o (ser_busy),
        .last_o (ser_last)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        csum_d  = csum_q;
        if (cfg_start) begin
            state_d = ST_LOAD;
            count_d = '0;
            csum_d  = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        csum_d  = cfg_csum_fold(csum_q, cfg_data);
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ser_busy && ser_last) begin
                        count_d = count_q + CNT_W'(1);
                        state_d = (count_d == N_BYTES) ? ST_CHECK : ST_LOAD;
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        state_d = (cfg_data == csum_q) ? ST_LATCH : ST_ERR;
                    end
                end
                ST_LATCH: state_d = ST_DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            csum_q  <= '0;
            ready_q <= 1'b0;
            shift_q <= 1'b0;
            latch_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            csum_q  <= csum_d;
            ready_q <= (state_d == ST_LOAD) || (state_d == ST_CHECK);
            shift_q <= (state_d == ST_SHIFT);
            latch_q <= (state_d == ST_LATCH);
            done_q  <= (state_d == ST_DONE);
            err_q   <= (state_d == ST_ERR);
        end
    end

    assign chain_shift_en = shift_q;
    assign chain_sdo      = shift_q & ser_sdo;
    assign chain_latch    = latch_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader: a 16-bit chain instance for protocol scenarios and
// a 256-bit instance for a full random image, both checked against a bit-stream model.
module tb_fpga_cfg_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, valid_a, ready_a, sdo_a, sh_a, latch_a, done_a, err_a;
    logic [7:0] data_a;
    logic       start_b, valid_b, ready_b, sdo_b, sh_b, latch_b, done_b, err_b;
    logic [7:0] data_b;

    fpga_cfg_loader #(.CHAIN_LEN(16), .CNT_W(6)) dut_a (
        .clk(clk), .rst_n(rst_n), .cfg_start(start_a), .cfg_data(data_a),
        .cfg_valid(valid_a), .cfg_ready(ready_a), .chain_sdo(sdo_a),
        .chain_shift_en(sh_a), .chain_latch(latch_a), .done(done_a), .err(err_a)
    );

    fpga_cfg_loader #(.CHAIN_LEN(256), .CNT_W(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_start(start_b), .cfg_data(data_b),
        .cfg_valid(valid_b), .cfg_ready(ready_b), .chain_sdo(sdo_b),
        .chain_shift_en(sh_b), .chain_latch(latch_b), .done(done_b), .err(err_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    bit   q_a[$];
    bit   q_b[$];
    int   lat_a = 0, lat_b = 0, acc_a = 0, acc_b = 0, viol = 0, cyc = 0;

    bit         exp_bits[$];
    logic [7:0] img[0:31];
    logic [7:0] img_csum;

    always @(posedge clk) cyc <= cyc + 1;

    // Chain model: every cycle with shift_en high moves one sdo bit into the chain.
    always @(negedge clk) begin
        if (sh_a) q_a.push_back(sdo_a);
        if (latch_a) lat_a++;
        if (valid_a && ready_a) acc_a++;
        if ((done_a && err_a) || (!sh_a && sdo_a) || (ready_a && sh_a)) viol++;
        if (sh_b) q_b.push_back(sdo_b);
        if (latch_b) lat_b++;
        if (valid_b && ready_b) acc_b++;
        if ((done_b && err_b) || (!sh_b && sdo_b) || (ready_b && sh_b)) viol++;
    end

    task automatic model_from_img(input int n);
        exp_bits.delete();
        img_csum = 8'h00;
        for (int k = 0; k < n; k++) begin
            img_csum = img_csum ^ img[k];
            for (int i = 0; i < 8; i++) exp_bits.push_back(img[k][i]);
        end
    endtask

    task automatic make_random(input int n);
        for (int k = 0; k < n; k++) img[k] = 8'($urandom);
        model_from_img(n);
    endtask

    task automatic pulse_start_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    task automatic pulse_start_b();
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] b, output bit ok);
        data_a = b; valid_a = 1'b1; ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (ready_a) ok = 1'b1;
        end
        if (ok) begin @(posedge clk); #1; end
        valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b, output bit ok);
        data_b = b; valid_b = 1'b1; ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (ready_b) ok = 1'b1;
        end
        if (ok) begin @(posedge clk); #1; end
        valid_b = 1'b0;
    endtask

    task automatic run_image_a(input int n, input logic [7:0] cs, output bit ok);
        bit o;
        ok = 1'b1;
        for (int k = 0; k < n; k++) begin send_a(img[k], o); ok = ok & o; end
        send_a(cs, o); ok = ok & o;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_image_b(input int n, input logic [7:0] cs, output bit ok);
        bit o;
        ok = 1'b1;
        for (int k = 0; k < n; k++) begin send_b(img[k], o); ok = ok & o; end
        send_b(cs, o); ok = ok & o;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_a = 0; valid_a = 0; data_a = 0;
        start_b = 0; valid_b = 0; data_b = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({ready_a, sdo_a, sh_a, latch_a, done_a, err_a} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_a: got %b want 000000", {ready_a, sdo_a, sh_a, latch_a, done_a, err_a});
        end
        n_cmp++;
        if ({ready_b, sdo_b, sh_b, latch_b, done_b, err_b} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_b: got %b want 000000", {ready_b, sdo_b, sh_b, latch_b, done_b, err_b});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ready_a !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready: got %b want 0", ready_a);
        end
    endtask

    task automatic test_good_image();
        bit ok;
        int bad = 0;
        bit e16[16] = '{1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0};
        img[0] = 8'hA5; img[1] = 8'h3C;
        pulse_start_a();
        q_a.delete(); lat_a = 0;
        run_image_a(2, 8'h99, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL good_timeout: got %b want 1", ok); end
        n_cmp++;
        if (q_a.size() !== 16) begin n_fail++; $display("FAIL good_shift_cnt: got %0d want 16", q_a.size()); end
        for (int i = 0; i < 16; i++) if (i >= q_a.size() || q_a[i] !== e16[i]) bad++;
        n_cmp++;
        if (bad !== 0) begin n_fail++; $display("FAIL good_stream: got %0d wrong bits want 0", bad); end
        n_cmp++;
        if ({lat_a, done_a, err_a, ready_a} !== {32'd1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL good_end: got latches=%0d done=%b err=%b ready=%b want 1 1 0 0", lat_a, done_a, err_a, ready_a);
        end
    endtask

    task automatic test_bad_checksum();
        bit ok;
        int a0, rdy = 0;
        img[0] = 8'hA5; img[1] = 8'h3C;
        pulse_start_a();
        lat_a = 0;
        run_image_a(2, 8'h98, ok);
        n_cmp++;
        if ({ok, lat_a, done_a, err_a} !== {1'b1, 32'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL bad_csum: got ok=%b latches=%0d done=%b err=%b want 1 0 0 1", ok, lat_a, done_a, err_a);
        end
        a0 = acc_a;
        data_a = 8'h99; valid_a = 1'b1;
        repeat (20) begin @(negedge clk); if (ready_a) rdy++; end
        valid_a = 1'b0;
        n_cmp++;
        if (rdy !== 0 || acc_a !== a0 || err_a !== 1'b1) begin
            n_fail++;
            $display("FAIL err_hold: got ready_cycles=%0d accepts=%0d err=%b want 0 0 1", rdy, acc_a - a0, err_a);
        end
    endtask

    task automatic test_back_to_back();
        int rdy_cyc[$];
        int idx = 0, a0, bad = 0;
        make_random(2);
        pulse_start_a();
        q_a.delete(); lat_a = 0; a0 = acc_a;
        data_a = img[0]; valid_a = 1'b1;
        for (int c = 0; c < 60 && idx < 3; c++) begin
            @(negedge clk);
            if (ready_a) begin
                rdy_cyc.push_back(cyc);
                idx++;
                @(posedge clk); #1;
                data_a = (idx < 2) ? img[idx] : img_csum;
            end
        end
        repeat (10) @(posedge clk);
        #1 valid_a = 1'b0;
        n_cmp++;
        if (rdy_cyc.size() !== 3 || acc_a - a0 !== 3) begin
            n_fail++;
            $display("FAIL b2b_accepts: got ready=%0d accepts=%0d want 3 3", rdy_cyc.size(), acc_a - a0);
        end else begin
            n_cmp++;
            if (rdy_cyc[1] - rdy_cyc[0] !== 9 || rdy_cyc[2] - rdy_cyc[1] !== 9) begin
                n_fail++;
                $display("FAIL b2b_gap: got %0d,%0d want 9,9", rdy_cyc[1] - rdy_cyc[0], rdy_cyc[2] - rdy_cyc[1]);
            end
        end
        for (int i = 0; i < exp_bits.size(); i++) if (i >= q_a.size() || q_a[i] !== exp_bits[i]) bad++;
        n_cmp++;
        if (bad !== 0 || q_a.size() !== 16 || lat_a !== 1 || done_a !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_image: got bad=%0d bits=%0d latches=%0d done=%b want 0 16 1 1", bad, q_a.size(), lat_a, done_a);
        end
    endtask

    task automatic test_abort();
        bit ok;
        int a0, bad = 0;
        send_a(8'h00, ok);
        pulse_start_a();
        send_a(8'($urandom) | 8'h01, ok);
        repeat (2) @(posedge clk);
        #1;
        a0 = acc_a;
        start_a = 1'b1; valid_a = 1'b1; data_a = 8'h5A;
        @(negedge clk);
        n_cmp++;
        if (ready_a !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b want 0", ready_a); end
        @(posedge clk); #1 start_a = 1'b0; valid_a = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (sh_a !== 1'b0 || acc_a !== a0) begin
            n_fail++;
            $display("FAIL abort_state: got shift_en=%b accepts=%0d want 0 0", sh_a, acc_a - a0);
        end
        make_random(2);
        @(posedge clk); #1;
        q_a.delete(); lat_a = 0;
        run_image_a(2, img_csum, ok);
        for (int i = 0; i < exp_bits.size(); i++) if (i >= q_a.size() || q_a[i] !== exp_bits[i]) bad++;
        n_cmp++;
        if ({ok, lat_a, done_a, err_a} !== {1'b1, 32'd1, 1'b1, 1'b0} || bad !== 0) begin
            n_fail++;
            $display("FAIL abort_reload: got ok=%b latches=%0d done=%b err=%b bad=%0d want 1 1 1 0 0", ok, lat_a, done_a, err_a, bad);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int a0, rdy = 0;
        pulse_start_a();
        lat_a = 0;
        send_a(8'($urandom), ok);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ready_a, sdo_a, sh_a, latch_a, done_a, err_a} !== 6'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b want 000000", {ready_a, sdo_a, sh_a, latch_a, done_a, err_a});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        a0 = acc_a;
        data_a = 8'hC3; valid_a = 1'b1;
        repeat (20) begin @(negedge clk); if (ready_a) rdy++; end
        valid_a = 1'b0;
        n_cmp++;
        if (rdy !== 0 || acc_a !== a0 || lat_a !== 0 || done_a !== 1'b0 || err_a !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got ready=%0d accepts=%0d latches=%0d done=%b err=%b want 0 0 0 0 0",
                     rdy, acc_a - a0, lat_a, done_a, err_a);
        end
    endtask

    task automatic test_long_image();
        bit ok;
        int bad = 0;
        make_random(32);
        pulse_start_b();
        q_b.delete(); lat_b = 0;
        run_image_b(32, img_csum, ok);
        n_cmp++;
        if (ok !== 1'b1 || q_b.size() !== 256) begin
            n_fail++;
            $display("FAIL long_shift: got ok=%b bits=%0d want 1 256", ok, q_b.size());
        end
        for (int i = 0; i < 256; i++) if (i >= q_b.size() || q_b[i] !== exp_bits[i]) bad++;
        n_cmp++;
        if (bad !== 0) begin n_fail++; $display("FAIL long_stream: got %0d wrong bits want 0", bad); end
        n_cmp++;
        if ({lat_b, done_b, err_b} !== {32'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL long_end: got latches=%0d done=%b err=%b want 1 1 0", lat_b, done_b, err_b);
        end
    endtask

    task automatic test_invariants();
        n_cmp++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL invariants: got %0d violating cycles want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_good_image();
        test_bad_checksum();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_long_image();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
